// File: rtl/param_sipo_pkg.sv
// param_sipo_pkg: shared FSM state encoding and frame-length helper for the SIPO receiver.
// PARITY_CHECK_EN adds one even-parity strobe to every frame.
package param_sipo_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    PARITY = ST_PARITY,
    HOLD   = ST_HOLD
  } state_t;
`ifdef PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  function automatic int frame_len(input int width);
    return width + (PARITY_EN ? 1 : 0);
  endfunction
endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: strobe counter for one frame; tc flags the strobe that completes the frame.
// With PARITY_CHECK_EN, data_last additionally flags the final data bit ahead of the parity strobe.
module sipo_bit_counter
  import param_sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
`ifdef PARITY_CHECK_EN
  ,
  output logic data_last
`endif
);
  localparam int TERMINAL = frame_len(WIDTH);
  localparam int CW = $clog2(TERMINAL + 1);
  logic [CW-1:0] count_q, count_d;
  // clear and increment together means the clearing strobe is itself bit one of a new frame
  always_comb begin
    count_d = clr ? CW'(inc) : count_q + CW'(inc);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  end
  assign tc = count_q == CW'(TERMINAL - 1);
`ifdef PARITY_CHECK_EN
  assign data_last = count_q == CW'(WIDTH - 1);
`endif
endmodule

// File: rtl/param_sipo_receiver.sv
// param_sipo_receiver: MSB-first serial-to-parallel receiver with valid/ready output and overrun flag.
// Defining PARITY_CHECK_EN adds an even-parity strobe per frame and the parity_err output.
module param_sipo_receiver
  import param_sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, data_q, data_d, shifted;
  logic valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;
  logic cnt_clr, cnt_inc, tc, take_start;
`ifdef PARITY_CHECK_EN
  logic perr_q, perr_d, data_last;
`endif
  assign shifted = {shreg_q[WIDTH-2:0], serial_in};
  // a start while holding an unaccepted word is only honoured together with data_ready
  assign take_start = start & ((state_q != HOLD) | data_ready);
  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .tc       (tc)
`ifdef PARITY_CHECK_EN
    ,
    .data_last(data_last)
`endif
  );
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    ovr_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d  = perr_q;
`endif
    if (take_start) begin
      state_d = SHIFT;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      cnt_clr = 1'b1;
      cnt_inc = bit_valid;
      shreg_d = bit_valid ? shifted : shreg_q;
`ifdef PARITY_CHECK_EN
      perr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_valid) begin
            shreg_d = shifted;
            cnt_inc = 1'b1;
`ifdef PARITY_CHECK_EN
            if (data_last) state_d = PARITY;
`else
            if (tc) begin
              state_d = HOLD;
              data_d  = shifted;
              valid_d = 1'b1;
              busy_d  = 1'b0;
              cnt_inc = 1'b0;
              cnt_clr = 1'b1;
            end
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (bit_valid && tc) begin
            state_d = HOLD;
            data_d  = shreg_q;
            perr_d  = ^{shreg_q, serial_in};
            valid_d = 1'b1;
            busy_d  = 1'b0;
            cnt_clr = 1'b1;
          end
        end
`endif
        HOLD: begin
          if (data_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
`ifdef PARITY_CHECK_EN
            perr_d  = 1'b0;
`endif
          end else begin
            ovr_d = bit_valid | start;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_param_sipo_receiver.sv
// tb_param_sipo_receiver: directed, table-driven checks of the SIPO receiver (WIDTH=8).
module tb_param_sipo_receiver;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic serial_in = 1'b0;
  logic data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic data_valid, busy, overrun;
`ifdef PARITY_CHECK_EN
  logic parity_err;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;

  param_sipo_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_valid (bit_valid),
    .serial_in (serial_in),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .overrun   (overrun)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  typedef struct {
    logic [W-1:0] word;
    bit           sep_start;
    int           hold_cycles;
    logic [W-1:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input bit sep_start);
    if (sep_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
    end
    for (int i = W - 1; i >= 0; i--) begin
      start = !sep_start && i == W - 1;
      bit_valid = 1'b1;
      serial_in = w[i];
      tick();
    end
`ifdef PARITY_CHECK_EN
    start = 1'b0;
    serial_in = ^w;
    tick();
`endif
    start = 1'b0;
    bit_valid = 1'b0;
  endtask

  task automatic accept();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("valid_after_accept", data_valid, 0);
  endtask

  initial begin
    int o0;
    vecs = '{
      '{8'hA5, 1'b1, 0, 8'hA5},
      '{8'h3C, 1'b0, 2, 8'h3C},
      '{8'hFF, 1'b0, 0, 8'hFF},
      '{8'h00, 1'b1, 1, 8'h00},
      '{8'h81, 1'b0, 3, 8'h81}
    };
    #2 reset = 1'b0;
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("idle_strobe_overrun", overrun, 0);
    check("idle_strobe_busy", busy, 0);

    foreach (vecs[k]) begin
      o0 = ovr_cnt;
      send(vecs[k].word, vecs[k].sep_start);
      check("vec_valid", data_valid, 1);
      check("vec_data", data_out, vecs[k].exp_data);
      check("vec_busy", busy, 0);
      for (int c = 0; c < vecs[k].hold_cycles; c++) begin
        tick();
        check("vec_hold_valid", data_valid, 1);
        check("vec_hold_data", data_out, vecs[k].exp_data);
      end
      accept();
      check("vec_busy_idle", busy, 0);
      check("vec_no_overrun", ovr_cnt - o0, 0);
    end

    send(8'h3C, 1'b0);
    o0 = ovr_cnt;
    for (int c = 0; c < 5; c++) begin
      bit_valid = (c == 1 || c == 3);
      serial_in = 1'b1;
      tick();
      check("bp_overrun_pulse", overrun, (c == 1 || c == 3) ? 1 : 0);
      check("bp_data", data_out, 8'h3C);
      check("bp_valid", data_valid, 1);
    end
    bit_valid = 1'b0;
    check("bp_overrun_count", ovr_cnt - o0, 2);
    accept();

    o0 = ovr_cnt;
    start = 1'b1;
    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    start = 1'b0;
    serial_in = 1'b1;
    tick();
    serial_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("abort_busy", busy, 1);
    send(8'hF0, 1'b0);
    check("abort_valid", data_valid, 1);
    check("abort_data", data_out, 8'hF0);
    check("abort_no_overrun", ovr_cnt - o0, 0);
    accept();

    start = 1'b1;
    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bit_valid = 1'b0;
    check("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_mid_busy", busy, 0);
    check("async_mid_valid", data_valid, 0);
    reset = 1'b1;
    tick();
    send(8'h5A, 1'b0);
    check("hold_valid_pre_rst", data_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("async_hold_valid", data_valid, 0);
    check("async_hold_data", data_out, 0);
    reset = 1'b1;
    tick();
    send(8'h81, 1'b1);
    check("post_rst_data", data_out, 8'h81);
    check("post_rst_valid", data_valid, 1);

    data_ready = 1'b1;
    start = 1'b1;
    bit_valid = 1'b1;
    serial_in = 1'b1;
    tick();
    data_ready = 1'b0;
    start = 1'b0;
    check("restart_valid", data_valid, 0);
    check("restart_busy", busy, 1);
    for (int i = W - 2; i >= 0; i--) begin
      logic [W-1:0] nw;
      nw = 8'hB3;
      serial_in = nw[i];
      tick();
    end
`ifdef PARITY_CHECK_EN
    serial_in = ^8'hB3;
    tick();
`endif
    bit_valid = 1'b0;
    check("restart_valid2", data_valid, 1);
    check("restart_data", data_out, 8'hB3);
    accept();

`ifdef PARITY_CHECK_EN
    for (int p = 1; p >= 0; p--) begin
      logic [W-1:0] pw;
      pw = 8'h07;
      start = 1'b1;
      for (int i = W - 1; i >= 0; i--) begin
        bit_valid = 1'b1;
        serial_in = pw[i];
        tick();
        start = 1'b0;
      end
      serial_in = p[0];
      tick();
      bit_valid = 1'b0;
      check("par_data", data_out, 8'h07);
      check("par_err", parity_err, (p == 1) ? 0 : 1);
      accept();
      check("par_err_cleared", parity_err, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/param_sipo_receiver.md
# param_sipo_receiver

Serial-in/parallel-out receiver forming the far end of the parameterized shift-register link: it collects a WIDTH-bit frame arriving MSB first (one bit per `bit_valid` strobe) into a parallel word. The completed word is presented on `data_out` with a valid/ready handshake. It sits between the serial link and the consuming datapath, and flags overrun and, optionally, parity errors.

## Interface
- `WIDTH`, default 8: frame width in bits; legal range ≥ 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `reset`  in  1: reset, asynchronous, active-low.
- `start`  in  1: frame start; clears the bit count and begins a new frame.
- `bit_valid`  in  1: sample strobe; `serial_in` is captured on each clock edge where this is high.
- `serial_in`  in  1: serial data, MSB first.
- `data_ready`  in  1: consumer accepts `data_out` when both `data_valid` and `data_ready` are high.
- `data_out`  out  WIDTH: received word; stable while `data_valid` is high.
- `data_valid`  out  1: word available.
- `busy`  out  1: frame in progress (SHIFT or PARITY state).
- `overrun`  out  1: one-cycle pulse when a bit or a start is dropped.
- `parity_err`  out  1: present only with `PARITY_CHECK_EN`.

## Operation
States:
- **IDLE**
  - `start` → SHIFT, count = 0.
  - A `bit_valid` in the same cycle as `start` is captured as the MSB, with count = 1.
  - A `bit_valid` without `start` is ignored, with no overrun.
- **SHIFT**
  - On `bit_valid`: `shreg <= {shreg[WIDTH-2:0], serial_in}` and count increments.
  - On the WIDTH-th bit: go to PARITY if enabled, otherwise go to HOLD, load `data_out <= {shreg[WIDTH-2:0], serial_in}`, and set `data_valid`.
  - `start` during SHIFT aborts the frame: count = 0, partial data discarded, no overrun. A simultaneous `bit_valid` is taken as the new MSB.
- **PARITY** (macro only)
  - The next `bit_valid` captures the parity bit.
  - Then go to HOLD, load `data_out`, and set `parity_err` = XOR(word, parity bit) (even parity expected).
- **HOLD**
  - `data_valid` = 1; `data_out` and `parity_err` are held.
  - On `data_ready`: clear `data_valid` and go to IDLE. If `start` is also high, go directly to SHIFT, with the same-cycle `bit_valid` rule as IDLE.
  - `bit_valid` or `start` without `data_ready`: input dropped, `overrun` pulses for 1 cycle, state unchanged.
- Count register is `$clog2(WIDTH+1)` bits wide; it never wraps, because the count resets on frame completion.
- `shreg` is not cleared between frames; only the shifted-in bits matter.

## Timing
- Reset values: state IDLE, `data_out` = 0, `data_valid` = 0, `busy` = 0, `overrun` = 0, `parity_err` = 0, count = 0.
- Latency: `data_valid` rises in the cycle after the edge that samples the last bit (or the parity bit). Back-to-back bits at 1 per cycle are supported.
- `busy` is registered: high from the cycle after `start` until the cycle `data_valid` rises.
- `data_valid` falls in the cycle after the accepting edge. The minimum gap between two words is 1 cycle plus WIDTH bit strobes.
- Reset asserted mid-frame or in HOLD: all outputs go to their reset values immediately (asynchronously); the partial frame is lost.
- `overrun` is a registered one-cycle pulse; it is never sticky.

## Configuration
- `PARITY_CHECK_EN` defined:
  - Each frame is WIDTH+1 strobes; the last strobe is an even-parity bit.
  - The PARITY state and the `parity_err` output exist.
  - `parity_err` is valid exactly while `data_valid` is high and is 0 otherwise.
- `PARITY_CHECK_EN` undefined:
  - A frame is exactly WIDTH strobes.
  - There is no PARITY state and no `parity_err` port.

## Structure
- Package `param_sipo_pkg`: state enum typedef (IDLE, SHIFT, PARITY, HOLD) and 2-bit state encoding constants.
- Sub-module `sipo_bit_counter`: parameterized counter with clear, increment, and terminal-count flag (terminal at WIDTH, or WIDTH+1 with parity).
- The top level holds the FSM, the shift register, the output register, and the handshake logic.

## Test plan
- **Basic frame**: WIDTH=8, `start`, then 8 consecutive strobes of bits 1,0,1,0,0,1,0,1 → `data_out` = 8'hA5 with `data_valid` high one cycle after the 8th strobe; `data_ready` high → `data_valid` low next cycle and state IDLE.
- **Backpressure/overrun**: frame 8'h3C, `data_ready` held at 0 for 5 cycles with 2 `bit_valid` pulses → `data_out` stays 8'h3C, `overrun` pulses twice, then accept succeeds.
- **Abort**: `start`, 3 bits, `start` again, then 8 bits of 8'hF0 → `data_out` = 8'hF0, `overrun` never asserted.
- **Async reset mid-frame**: reset low after 4 bits → all outputs 0 in the same cycle; a fresh frame of 8'h81 afterwards completes correctly.
- **Accept-and-restart**: `data_ready` and `start` plus `bit_valid` (bit = 1) in the same HOLD cycle, followed by 7 more bits → next word MSB = 1, no idle gap.
- **Parity** (`PARITY_CHECK_EN`): 8'h07 with parity bit 1 → `parity_err` = 0; 8'h07 with parity bit 0 → `parity_err` = 1 while `data_valid` is high.
